// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: debounced switch/operand front-end issuing ALU ops over valid/ready with optional auto-scan.
// Define ALU_SW_CONFLICT_EN to flag and suppress manual issues when more than one switch is on.
module alu_op_scheduler #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_CYCLES     = 50000000,
    parameter int OPERAND_W       = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           sw_in,
    input  logic [OPERAND_W-1:0] operands_in,
    input  logic                 scan_en,
    input  logic                 op_ready,
    output logic                 op_valid,
    output logic [2:0]           op_sel,
    output logic [OPERAND_W-1:0] operands_q,
    output logic                 scan_active,
    output logic                 sw_conflict
);
    localparam int RW = OPERAND_W + 6;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int SW = SCAN_CYCLES > 1 ? $clog2(SCAN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, SCAN_ISSUE, DWELL} state_t;
    state_t state, state_n;

    logic [RW-1:0]        raw, prev, stable;
    logic [DW-1:0]        db_cnt;
    logic [SW-1:0]        dwell_cnt;
    logic [5:0]           s_sw;
    logic [OPERAND_W-1:0] s_ops, last_ops;
    logic [2:0]           enc, last_sel;
    logic                 settled, dwell_done, manual_req;

    assign raw         = {sw_in, operands_in};
    assign settled     = raw == prev && db_cnt == DW'(DEBOUNCE_CYCLES - 1);
    assign s_sw        = stable[RW-1 -: 6];
    assign s_ops       = stable[OPERAND_W-1:0];
    // sw6 outranks sw5 and sw4 by design of the front panel
    assign enc         = s_sw[0] ? 3'd1 : s_sw[1] ? 3'd2 : s_sw[2] ? 3'd3 :
                         s_sw[5] ? 3'd6 : s_sw[4] ? 3'd5 : s_sw[3] ? 3'd4 : 3'd0;
    assign manual_req  = {enc, s_ops} != {last_sel, last_ops} && !sw_conflict;
    assign dwell_done  = dwell_cnt == SW'(SCAN_CYCLES - 1);
    assign op_valid    = state == ISSUE || state == SCAN_ISSUE;
    assign scan_active = state == SCAN_ISSUE || state == DWELL;

`ifdef ALU_SW_CONFLICT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst)
            sw_conflict <= 1'b0;
        else if (settled)
            sw_conflict <= $countones(raw[RW-1 -: 6]) > 1;
`else
    assign sw_conflict = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = scan_en ? SCAN_ISSUE : manual_req ? ISSUE : IDLE;
            ISSUE:      state_n = op_ready ? IDLE : ISSUE;
            SCAN_ISSUE: state_n = !op_ready ? SCAN_ISSUE : scan_en ? DWELL : IDLE;
            default:    state_n = !scan_en ? IDLE : dwell_done ? SCAN_ISSUE : DWELL;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            prev       <= '0;
            stable     <= '0;
            db_cnt     <= '0;
            dwell_cnt  <= '0;
            last_sel   <= '0;
            last_ops   <= '0;
            op_sel     <= '0;
            operands_q <= '0;
        end else begin
            state     <= state_n;
            prev      <= raw;
            db_cnt    <= raw != prev ? '0 : settled ? db_cnt : db_cnt + 1'b1;
            dwell_cnt <= state == DWELL && state_n == DWELL ? dwell_cnt + 1'b1 : '0;
            if (settled)
                stable <= raw;
            if (op_valid && op_ready) begin
                last_sel <= op_sel;
                last_ops <= operands_q;
            end
            if (state == IDLE && state_n != IDLE) begin
                op_sel     <= scan_en ? 3'd0 : enc;
                operands_q <= s_ops;
            end else if (state == DWELL && state_n == SCAN_ISSUE) begin
                op_sel     <= op_sel == 3'd6 ? 3'd0 : op_sel + 3'd1;
                operands_q <= s_ops;
            end
        end
endmodule
